muldiv_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_core.sv | 64 ++++++
 rtl/muldiv_seq.sv | 122 ++++++++++++
 tb/tb_muldiv_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the
// multi-cycle MUL/DIV sequencer.
package muldiv_pkg;

  localparam logic [3:0] ALUCTL_MUL = 4'b1000;
  localparam logic [3:0] ALUCTL_DIV = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_t;

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: shift-add multiply and restoring
// divide datapath, one iteration per step.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  op_t             op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] prod,
  output logic [XLEN-1:0] quo
);

  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN:0]   rem;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   dvs;
  logic            ge;

  // opa doubles as dividend shifter and quotient collector
  always_comb begin
    rem_sh = {rem[XLEN-1:0], opa[XLEN-1]};
    dvs    = {1'b0, opb};
    ge     = rem_sh >= dvs;
  end

  // operand load and per-step iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      opa <= '0;
      opb <= '0;
      rem <= '0;
    end else if (load) begin
      acc <= '0;
      opa <= a_in;
      opb <= b_in;
      rem <= '0;
    end else if (step) begin
      if (op == OP_MUL) begin
        if (opb[0]) acc <= acc + opa;
        opa <= opa << 1;
        opb <= opb >> 1;
      end else if (ge) begin
        rem <= rem_sh - dvs;
        opa <= {opa[XLEN-2:0], 1'b1};
      end else begin
        rem <= rem_sh;
        opa <= {opa[XLEN-2:0], 1'b0};
      end
    end
  end

  assign prod = acc;
  assign quo  = opa;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: FSM, iteration counter and result
// handshake around the muldiv_core datapath.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t          state;
  state_t          next;
  op_t             op_q;
  logic            sign_q;
  logic [CW-1:0]   count;
  logic            legal;
  logic            is_div;
  logic            dz;
  logic            accept;
  logic            load;
  logic            step;
  logic [XLEN-1:0] a_ld;
  logic [XLEN-1:0] b_ld;
  logic [XLEN-1:0] prod;
  logic [XLEN-1:0] quo;

  // request decode and operand magnitude for DIV
  always_comb begin
    is_div = 1'b0;
    legal  = 1'b0;
    unique case (1'b1)
      alu_ctrl == ALUCTL_MUL: legal = 1'b1;
      alu_ctrl == ALUCTL_DIV: begin
        legal  = 1'b1;
        is_div = 1'b1;
      end
      default: ;
    endcase
    dz     = is_div && (src_b == '0);
    accept = (state == IDLE) && start && legal && !flush;
    a_ld   = (is_div && src_a[XLEN-1]) ? -src_a : src_a;
    b_ld   = (is_div && src_b[XLEN-1]) ? -src_b : src_b;
    busy   = (state == RUN) || (state == FIX) ||
             ((state == IDLE) && start && legal);
  end

  // next state and datapath controls
  always_comb begin
    next = state;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        load = 1'b1;
        next = dz ? DONE : RUN;
      end
      RUN: begin
        step = 1'b1;
        if (count == LAST) next = FIX;
      end
      FIX:  next = DONE;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
    if (flush) begin
      next = IDLE;
      step = 1'b0;
    end
  end

  // state, counter, op latch and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= OP_MUL;
      sign_q <= 1'b0;
      count  <= '0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      state <= next;
      valid <= (next == DONE);
      if (load) begin
        op_q   <= is_div ? OP_DIV : OP_MUL;
        sign_q <= is_div && (src_a[XLEN-1] ^ src_b[XLEN-1]);
        count  <= '0;
        if (dz) result <= '1;
      end else if (step) begin
        count <= count + 1'b1;
      end
      if (state == FIX && !flush) begin
        if (op_q == OP_MUL) result <= prod;
        else result <= sign_q ? -quo : quo;
      end
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .op      (op_q),
    .a_in    (a_ld),
    .b_in    (b_ld),
    .prod    (prod),
    .quo     (quo)
  );

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors against a
// behavioural arithmetic model and scoreboard.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          due;
  } pend_t;

  pend_t       pq[$];
  int          cyc = 0;
  int          nerr = 0;
  int          nchk = 0;
  logic [31:0] model_res = '0;
  logic        exp_v;

  muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic div,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] p;
    longint      q;
    if (!div) begin
      p = {32'b0, a} * {32'b0, b};
      return p[31:0];
    end
    if (b == 0) return 32'hFFFF_FFFF;
    q = longint'($signed(a)) / longint'($signed(b));
    return q[31:0];
  endfunction

  // scoreboard compare on every cycle out of reset
  always @(negedge clk) begin
    if (reset_n) begin
      exp_v = (pq.size() > 0) && (pq[0].due == cyc);
      chk("valid", 32'(valid), 32'(exp_v));
      if (exp_v) begin
        model_res = pq[0].res;
        void'(pq.pop_front());
      end
      chk("result_hold", result, model_res);
    end
  end

  task automatic issue(input logic div,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = div ? ALUCTL_DIV : ALUCTL_MUL;
    src_a    = a;
    src_b    = b;
    pq.push_back(pend_t'{model(div, a, b),
                 cyc + ((div && b == 0) ? 1 : 34)});
  endtask

  task automatic run_op(input logic div,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int exp_busy,
                        input logic [31:0] lit,
                        input int poke);
    int   nb;
    logic seen;
    chk("model_pin", model(div, a, b), lit);
    issue(div, a, b);
    #1 nb = busy ? 1 : 0;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == poke) begin
        start    = 1'b1;
        alu_ctrl = ALUCTL_MUL;
        src_a    = 32'd9;
        src_b    = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (valid) begin
        seen = 1'b1;
        chk("busy_at_valid", 32'(busy), 32'd0);
        chk("result", result, lit);
      end else if (busy) begin
        nb++;
      end
    end
    start = 1'b0;
    chk("valid_seen", 32'(seen), 32'd1);
    chk("busy_cycles", 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    alu_ctrl = 4'h0;
    src_a    = '0;
    src_b    = '0;
    flush    = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(0, 32'd7, 32'd6, 34, 32'd42, -1);
    run_op(0, 32'hFFFF_FFFF, 32'd2, 34,
           32'hFFFF_FFFE, -1);
    run_op(1, -32'sd20, 32'd3, 34,
           32'hFFFF_FFFA, -1);
    run_op(1, 32'd100, 32'd0, 1,
           32'hFFFF_FFFF, -1);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 34,
           32'h8000_0000, -1);
    run_op(1, 32'd100, 32'd7, 34, 32'd14, -1);
    run_op(1, 32'd7, -32'sd2, 34,
           32'hFFFF_FFFD, -1);
    run_op(0, 32'd1234, 32'd5678, 34,
           32'd7006652, 11);

    // illegal alu_ctrl with start: nothing happens
    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = 4'b0000;
    #1 chk("illegal_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("illegal_busy2", 32'(busy), 32'd0);

    // flush at count 20 of a DIV
    issue(1, 32'd1000, 32'd10);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (21) @(negedge clk);
    flush = 1'b1;
    void'(pq.pop_back());
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result", result, 32'd7006652);
    repeat (3) begin
      @(negedge clk);
      chk("flush_valid", 32'(valid), 32'd0);
    end

    // asynchronous reset mid-RUN
    issue(0, 32'h1111, 32'd3);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    pq.delete();
    model_res = '0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op(0, 32'd3, 32'd5, 34, 32'd15, -1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
